// File: rtl/logic_element.sv
// logic_element: two LUTs with optional output flops, configured through a daisy-chained serial CRAM.
// Outputs are forced low while configuring so partial CRAM contents never reach the fabric.
module logic_element #(
    parameter int LE_INPUTS = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic                 config_en,
    input  logic                 config_data_in,
    output logic                 config_data_out,
    input  logic [LE_INPUTS-1:0] leinA,
    input  logic [LE_INPUTS-1:0] leinB,
    output logic                 leoutA,
    output logic                 leoutB,
    output logic                 cfg_valid
);
    localparam int LUT_SZ   = 2 ** LE_INPUTS;
    localparam int CFG_BITS = 2 * LUT_SZ + 4;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ffa_q, ffa_d, ffb_q, ffb_d;
    logic [LUT_SZ-1:0]   tt_a, tt_b;
    logic                lut_a, lut_b;

    assign tt_a  = cfg_q[CFG_BITS-1 -: LUT_SZ];
    assign tt_b  = cfg_q[LUT_SZ+3 -: LUT_SZ];
    assign lut_a = tt_a[leinA];
    assign lut_b = tt_b[leinB];

    always_comb begin
        cfg_d = config_en ? {cfg_q[CFG_BITS-2:0], config_data_in} : cfg_q;
        // preload from the post-shift image so the final shift edge leaves the new init values
        ffa_d = config_en ? cfg_d[1] : (en ? lut_a : ffa_q);
        ffb_d = config_en ? cfg_d[0] : (en ? lut_b : ffb_q);
        cnt_d = (config_en && cnt_q != CNT_FULL) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cfg_q <= '0;
            cnt_q <= '0;
            ffa_q <= 1'b0;
            ffb_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            cnt_q <= cnt_d;
            ffa_q <= ffa_d;
            ffb_q <= ffb_d;
        end
    end

    assign config_data_out = cfg_q[CFG_BITS-1];
    assign leoutA          = !config_en && (cfg_q[3] ? ffa_q : lut_a);
    assign leoutB          = !config_en && (cfg_q[2] ? ffb_q : lut_b);
    assign cfg_valid       = (cnt_q == CNT_FULL) && !config_en;
endmodule

// File: tb/tb_logic_element.sv
// tb_logic_element: directed vectors and sequences for LUT evaluation, registered mode, preload and the CRAM chain.
module tb_logic_element;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       en = 1'b0;
    logic       config_en = 1'b0;
    logic       config_data_in = 1'b0;
    logic       config_data_out;
    logic [3:0] leinA = 4'h0;
    logic [3:0] leinB = 4'h0;
    logic       leoutA, leoutB, cfg_valid;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ea;
        logic       eb;
    } vec_t;
    vec_t vecs[16];

    logic [71:0] cap;

    logic_element dut (
        .clk(clk), .nrst(nrst), .en(en), .config_en(config_en),
        .config_data_in(config_data_in), .config_data_out(config_data_out),
        .leinA(leinA), .leinB(leinB), .leoutA(leoutA), .leoutB(leoutB),
        .cfg_valid(cfg_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Shifts n bits of v MSB first; cap collects config_data_out seen just before each shift edge.
    task automatic shift(input logic [71:0] v, input int n, output logic [71:0] c);
        c = '0;
        @(negedge clk);
        config_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            config_data_in = v[n-1-i];
            #1;
            c = {c[70:0], config_data_out};
            @(negedge clk);
        end
        config_en = 1'b0;
        config_data_in = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        #1;
    endtask

    initial begin
        // power-on reset
        #2;
        chk("rst_leoutA", 36'(leoutA), 36'h0);
        chk("rst_leoutB", 36'(leoutB), 36'h0);
        chk("rst_cdo", 36'(config_data_out), 36'h0);
        chk("rst_valid", 36'(cfg_valid), 36'h0);
        @(negedge clk);
        nrst = 1'b1;

        // combinational LUTs: A = AND4, B = XOR4
        for (int i = 0; i < 16; i++) begin
            vecs[i].a  = 4'(i);
            vecs[i].b  = 4'(i) ^ 4'h5;
            vecs[i].ea = (i == 15);
            vecs[i].eb = ^(4'(i) ^ 4'h5);
        end
        shift({36'h0, 16'h8000, 16'h6996, 4'b0000}, 36, cap);
        chk("comb_valid", 36'(cfg_valid), 36'h1);
        for (int i = 0; i < 16; i++) begin
            leinA = vecs[i].a;
            leinB = vecs[i].b;
            #1;
            chk($sformatf("comb_A[%0d]", i), 36'(leoutA), 36'(vecs[i].ea));
            chk($sformatf("comb_B[%0d]", i), 36'(leoutB), 36'(vecs[i].eb));
        end

        // registered B (all-ones LUT, init 0); A stays combinational with MSB set in the chain
        leinA = 4'hF;
        leinB = 4'h0;
        shift({36'h0, 16'h8001, 16'hFFFF, 4'b0100}, 36, cap);
        chk("reg_B_init", 36'(leoutB), 36'h0);
        chk("reg_A_comb", 36'(leoutA), 36'h1);
        idle(2);
        chk("reg_B_hold_en0", 36'(leoutB), 36'h0);
        en = 1'b1;
        idle(1);
        en = 1'b0;
        chk("reg_B_update", 36'(leoutB), 36'h1);
        idle(3);
        chk("reg_B_hold", 36'(leoutB), 36'h1);
        chk("pre_rst_cdo", 36'(config_data_out), 36'h1);
        chk("pre_rst_valid", 36'(cfg_valid), 36'h1);

        // asynchronous reset mid-operation, between clock edges
        nrst = 1'b0;
        #1;
        chk("arst_leoutA", 36'(leoutA), 36'h0);
        chk("arst_leoutB", 36'(leoutB), 36'h0);
        chk("arst_cdo", 36'(config_data_out), 36'h0);
        chk("arst_valid", 36'(cfg_valid), 36'h0);
        @(negedge clk);
        nrst = 1'b1;

        // partial load of 20 bits: LUT B = 0xF0F3, reg/init = 0
        shift({52'h0, 20'hF0F30}, 20, cap);
        leinA = 4'hF;
        leinB = 4'h0;
        #1;
        chk("part_valid", 36'(cfg_valid), 36'h0);
        chk("part_B0", 36'(leoutB), 36'h1);
        leinB = 4'h2;
        #1;
        chk("part_B2", 36'(leoutB), 36'h0);
        chk("part_A", 36'(leoutA), 36'h0);
        leinB = 4'h4;
        #1;
        chk("part_B4", 36'(leoutB), 36'h1);
        config_en = 1'b1;
        #1;
        chk("force_B", 36'(leoutB), 36'h0);
        config_en = 1'b0;
        #1;
        chk("unforce_B", 36'(leoutB), 36'h1);

        // init preload with en held high through the load: config wins, flop shows initA
        leinA = 4'h0;
        en = 1'b1;
        shift({36'h0, 16'h0000, 16'h0000, 4'b1010}, 36, cap);
        chk("init_A", 36'(leoutA), 36'h1);
        chk("init_valid", 36'(cfg_valid), 36'h1);
        idle(1);
        chk("init_A_upd", 36'(leoutA), 36'h0);
        en = 1'b0;

        // chain pass-through of 72 bits
        shift({36'hA5A5A5A5A, 36'h123456789}, 72, cap);
        chk("chain_out", cap[35:0], 36'hA5A5A5A5A);
        chk("chain_cdo_end", 36'(config_data_out), 36'h0);
        // 0x123456789: LUT A=0x1234, LUT B=0x5678, regA=1, regB=0, initA=0, initB=1
        leinA = 4'h2;
        leinB = 4'h3;
        #1;
        chk("ld_A_init", 36'(leoutA), 36'h0);
        chk("ld_B3", 36'(leoutB), 36'h1);
        en = 1'b1;
        idle(1);
        en = 1'b0;
        chk("ld_A_reg", 36'(leoutA), 36'h1);
        shift(72'h0, 36, cap);
        chk("readback", cap[35:0], 36'h123456789);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
